// File: rtl/reg_file_8x16.sv
// Register file with one write port and two registered read ports. Reads see a
// same-cycle write (bypass). SelError is a sticky flag for malformed select vectors.
module reg_file_8x16 #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int ZERO_REG = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [NREGS-1:0] Rs1,
  input  logic [NREGS-1:0] Rs2,
  input  logic [NREGS-1:0] Rw,
  input  logic             We,
  input  logic [WIDTH-1:0] WData,
  output logic [WIDTH-1:0] Rs1Data,
  output logic [WIDTH-1:0] Rs2Data,
  output logic             SelError
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic             sel_error_q, sel_error_d;
  logic             wr_valid;

  function automatic logic is_onehot(input logic [NREGS-1:0] v);
    return (v != '0) && ((v & (v - NREGS'(1))) == '0);
  endfunction

  function automatic logic is_multihot(input logic [NREGS-1:0] v);
    return (v & (v - NREGS'(1))) != '0;
  endfunction

  // regs_d is the post-write view of the array, so selecting from it gives the bypass for free.
  function automatic logic [WIDTH-1:0] read_port(input logic [NREGS-1:0] sel,
                                                 input logic [WIDTH-1:0] view [NREGS]);
    logic [WIDTH-1:0] data;
    data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel[i]) data = data | view[i];
    end
    if (!is_onehot(sel)) data = '0;
    return data;
  endfunction

  assign wr_valid = We && is_onehot(Rw);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_valid && Rw[i]) regs_d[i] = WData;
    end
    if (ZERO_REG != 0) regs_d[0] = '0;

    rs1_data_d  = read_port(Rs1, regs_d);
    rs2_data_d  = read_port(Rs2, regs_d);
    sel_error_d = sel_error_q
                | (We && !wr_valid)
                | is_multihot(Rs1)
                | is_multihot(Rs2);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the array is a small flop bank that must read as zero after reset,
      // so it is cleared here rather than left to RAM-style uninitialised contents.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      sel_error_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign Rs1Data  = rs1_data_q;
  assign Rs2Data  = rs2_data_q;
  assign SelError = sel_error_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Bench for reg_file_8x16: drives one stimulus stream into a ZERO_REG=0 and a
// ZERO_REG=1 instance and checks both against a behavioural model and hand tables.
module tb_reg_file_8x16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rs1, rs2, rw;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] d0_rs1, d0_rs2, d1_rs1, d1_rs2;
  logic        d0_err, d1_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_8x16 #(.WIDTH(16), .NREGS(8), .ZERO_REG(0)) dut0 (
    .Clock(clk), .Reset(rst), .Rs1(rs1), .Rs2(rs2), .Rw(rw), .We(we), .WData(wdata),
    .Rs1Data(d0_rs1), .Rs2Data(d0_rs2), .SelError(d0_err)
  );

  reg_file_8x16 #(.WIDTH(16), .NREGS(8), .ZERO_REG(1)) dut1 (
    .Clock(clk), .Reset(rst), .Rs1(rs1), .Rs2(rs2), .Rw(rw), .We(we), .WData(wdata),
    .Rs1Data(d1_rs1), .Rs2Data(d1_rs2), .SelError(d1_err)
  );

  typedef struct {
    logic [15:0] d0_1, d0_2, d1_1, d1_2;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [7:0]  rs1, rs2, rw;
    logic        we;
    logic [15:0] wd;
    logic [15:0] e_rs1, e_rs2;
    logic        e_err;
  } vec_t;

  exp_t        sb_q[$];
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] sel, input bit zero_mode,
                                             input bit wvalid, input int widx,
                                             input logic [15:0] wd);
    int j;
    if ($countones(sel) != 1) return 16'h0;
    j = 0;
    for (int i = 0; i < 8; i++) if (sel[i]) j = i;
    if (zero_mode && j == 0) return 16'h0;
    if (wvalid && widx == j) return wd;
    return zero_mode ? m1[j] : m0[j];
  endfunction

  // One clock of stimulus: expectation pushed at drive time, popped and compared after the edge.
  task automatic step(input logic r, input logic [7:0] s1, input logic [7:0] s2,
                      input logic [7:0] w, input logic en, input logic [15:0] wd);
    exp_t e;
    exp_t got;
    bit   wvalid;
    int   widx;
    @(negedge clk);
    rst = r; rs1 = s1; rs2 = s2; rw = w; we = en; wdata = wd;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        m0[i] = 16'h0;
        m1[i] = 16'h0;
      end
      m_err = 1'b0;
      e = '{16'h0, 16'h0, 16'h0, 16'h0, 1'b0};
    end else begin
      wvalid = en && ($countones(w) == 1);
      widx = -1;
      for (int i = 0; i < 8; i++) if (w[i]) widx = i;
      e.d0_1 = model_read(s1, 1'b0, wvalid, widx, wd);
      e.d0_2 = model_read(s2, 1'b0, wvalid, widx, wd);
      e.d1_1 = model_read(s1, 1'b1, wvalid, widx, wd);
      e.d1_2 = model_read(s2, 1'b1, wvalid, widx, wd);
      if ((en && !wvalid) || $countones(s1) > 1 || $countones(s2) > 1) m_err = 1'b1;
      e.err = m_err;
      if (wvalid) begin
        m0[widx] = wd;
        if (widx != 0) m1[widx] = wd;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb_d0_rs1", d0_rs1, got.d0_1);
    check("sb_d0_rs2", d0_rs2, got.d0_2);
    check("sb_d1_rs1", d1_rs1, got.d1_1);
    check("sb_d1_rs2", d1_rs2, got.d1_2);
    check("sb_d0_err", d0_err, got.err);
    check("sb_d1_err", d1_err, got.err);
  endtask

  vec_t vecs [12];

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rw = '0; we = 1'b0; wdata = '0;

    // Expected values are for the ZERO_REG=0 instance, one cycle after each row is applied.
    vecs[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 8'h08, 8'h00, 8'h08, 1'b1, 16'h3333, 16'h3333, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 8'h08, 8'h08, 8'h00, 1'b0, 16'h0000, 16'h3333, 16'h3333, 1'b0};
    vecs[3]  = '{1'b0, 8'h20, 8'h20, 8'h20, 1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 8'h08, 8'h00, 1'b0, 16'h0000, 16'hBEEF, 16'h3333, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h20, 8'hFF, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1'b0};
    vecs[6]  = '{1'b0, 8'h08, 8'h20, 8'h00, 1'b0, 16'h0000, 16'h3333, 16'hBEEF, 1'b0};
    vecs[7]  = '{1'b0, 8'h03, 8'h08, 8'h06, 1'b1, 16'hFFFF, 16'h0000, 16'h3333, 1'b1};
    vecs[8]  = '{1'b0, 8'h02, 8'h04, 8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 8'h08, 8'h08, 8'h08, 1'b1, 16'h5555, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 8'h08, 8'h01, 8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};

    for (int v = 0; v < 12; v++) begin
      step(vecs[v].rst, vecs[v].rs1, vecs[v].rs2, vecs[v].rw, vecs[v].we, vecs[v].wd);
      check($sformatf("tbl%0d_rs1", v), d0_rs1, vecs[v].e_rs1);
      check($sformatf("tbl%0d_rs2", v), d0_rs2, vecs[v].e_rs2);
      check($sformatf("tbl%0d_err", v), d0_err, vecs[v].e_err);
    end

    // Reset, then every register reads zero on both ports.
    step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'(1 << k), 8'(1 << k), 8'h00, 1'b0, 16'h0);
      check("rst_rd_rs1", d0_rs1, 16'h0000);
      check("rst_rd_err", d0_err, 1'b0);
    end

    // Fill all registers with 0x1110*k+k and read them back.
    for (int k = 0; k < 8; k++)
      step(1'b0, 8'h00, 8'h00, 8'(1 << k), 1'b1, 16'(16'h1110 * k + k));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'(1 << k), 8'(1 << (7 - k)), 8'h00, 1'b0, 16'h0);
      if (k == 3) check("fill_r3", d0_rs1, 16'h3333);
    end

    // Zero-register instance discards a write to register 0 without raising an error.
    step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0);
    step(1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 16'hAAAA);
    step(1'b0, 8'h01, 8'h01, 8'h00, 1'b0, 16'h0);
    check("zr_rd0_z1", d1_rs1, 16'h0000);
    check("zr_err_z1", d1_err, 1'b0);
    check("zr_rd0_z0", d0_rs1, 16'hAAAA);

    // Reset lands in the middle of a write burst; its own write is dropped too.
    for (int k = 1; k <= 4; k++)
      step(k == 4, 8'h00, 8'h00, 8'(1 << k), 1'b1, 16'(16'hC000 | k));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'(1 << k), 8'(1 << k), 8'h00, 1'b0, 16'h0);
      check("burst_rs1", d0_rs1, 16'h0000);
      check("burst_rs2", d1_rs2, 16'h0000);
    end

    // Random traffic, including malformed selects, checked only against the model.
    step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0);
    for (int n = 0; n < 200; n++) begin
      logic [7:0] a, b, c;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      c = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      step(($urandom_range(0, 40) == 0), a, b, c, 1'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
